// File: rtl/display_pkg.sv
// Shared FSM state type and default parameter values for the display controller.
package display_pkg;

    typedef enum logic {
        WAIT_PRESS   = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_e;

    localparam int DEF_NUM_KEYS     = 10;
    localparam int DEF_SEL_W        = 5;
    localparam int DEF_COLOR_W      = 1;
    localparam int DEF_TICK_W       = 22;
    localparam int DEF_STARTUP_DISP = 6;
    localparam int DEF_STARTUP_CALC = 15;
    localparam int DEF_DEBOUNCE     = 2;
    localparam int DEF_DEFAULT_SEL  = 0;

endpackage

// File: rtl/frame_debounce.sv
// Once-per-frame key snapshot with a saturating count of consecutive identical,
// non-empty snapshots. stable_next is the count as it stands after this cycle's sample.
module frame_debounce
    import display_pkg::*;
#(
    parameter int SNAP_W   = DEF_NUM_KEYS + 2,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample,
    input  logic [SNAP_W-1:0] pressed,
    output logic [CNT_W-1:0]  stable_next
);

    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        if (sample) begin
            snap_d = pressed;
            if ((pressed == snap_q) && (pressed != '0)) begin
                cnt_d = (cnt_q == CNT_W'(DEBOUNCE)) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign stable_next = cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/display_ctrl_n.sv
// VGA-side controller: startup enables, registered pixel output and debounced
// preset selection that holds the calculation core in reset until keys are released.
module display_ctrl_n
    import display_pkg::*;
#(
    parameter int NUM_KEYS     = DEF_NUM_KEYS,
    parameter int SEL_W        = DEF_SEL_W,
    parameter int COLOR_W      = DEF_COLOR_W,
    parameter int TICK_W       = DEF_TICK_W,
    parameter int STARTUP_DISP = DEF_STARTUP_DISP,
    parameter int STARTUP_CALC = DEF_STARTUP_CALC,
    parameter int DEBOUNCE     = DEF_DEBOUNCE,
    parameter int DEFAULT_SEL  = DEF_DEFAULT_SEL
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 vnotactive,
    input  logic [NUM_KEYS-1:0]  keys_n,
    input  logic                 key_up_n,
    input  logic                 key_down_n,
    input  logic [3*COLOR_W-1:0] pix_in,
    output logic [3*COLOR_W-1:0] pix_out,
    output logic [SEL_W-1:0]     sel_num,
    output logic                 sel_load,
    output logic                 calc_rst,
    output logic                 calc_en,
    output logic                 disp_en,
    output state_e               state_dbg
);

    localparam int SNAP_W = NUM_KEYS + 2;
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int TCNT_W = $clog2(STARTUP_CALC + 1);

    logic [TICK_W-1:0]    presc_q, presc_d;
    logic [TCNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                 disp_en_q, disp_en_d, calc_en_q, calc_en_d;
    logic                 vnotactive_q, vnotactive_d;
    logic [3*COLOR_W-1:0] pix_out_q, pix_out_d;
    logic [SEL_W-1:0]     sel_num_q, sel_num_d;
    logic                 sel_load_q, sel_load_d, calc_rst_q, calc_rst_d;
    state_e               state_q, state_d;

    logic                 vb_rise, act, tick;
    logic [SNAP_W-1:0]    pressed;
    logic [CNT_W-1:0]     stable_next;
    logic [SEL_W-1:0]     low_idx;

    assign vb_rise = vnotactive & ~vnotactive_q;
    assign pressed = ~{key_down_n, key_up_n, keys_n};
    assign tick    = &presc_q;

    frame_debounce #(
        .SNAP_W   (SNAP_W),
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_debounce (
        .clk         (CLK),
        .rst         (RST),
        .sample      (vb_rise),
        .pressed     (pressed),
        .stable_next (stable_next)
    );

    // Startup enables are sticky; they rise on the same edge the tick count lands.
    always_comb begin
        presc_d      = presc_q + TICK_W'(1);
        tick_cnt_d   = tick_cnt_q;
        if (tick && (tick_cnt_q != TCNT_W'(STARTUP_CALC))) begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
        end
        disp_en_d    = disp_en_q | (tick_cnt_d >= TCNT_W'(STARTUP_DISP));
        calc_en_d    = calc_en_q | (tick_cnt_d >= TCNT_W'(STARTUP_CALC));
        vnotactive_d = vnotactive;
        pix_out_d    = disp_en_q ? pix_in : pix_out_q;
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pressed[i]) low_idx = SEL_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_num_d  = sel_num_q;
        sel_load_d = 1'b0;
        calc_rst_d = calc_rst_q;
        act        = 1'b0;
        case (state_q)
            WAIT_PRESS: begin
                calc_rst_d = 1'b0;
                if (vb_rise && calc_en_q && (stable_next == CNT_W'(DEBOUNCE))) begin
                    if (|pressed[NUM_KEYS-1:0]) begin
                        sel_num_d = low_idx;
                        act       = 1'b1;
                    end else if (pressed[NUM_KEYS] && !pressed[NUM_KEYS+1]) begin
                        sel_num_d = (sel_num_q == SEL_W'(NUM_KEYS - 1)) ? '0 : sel_num_q + SEL_W'(1);
                        act       = 1'b1;
                    end else if (pressed[NUM_KEYS+1] && !pressed[NUM_KEYS]) begin
                        sel_num_d = (sel_num_q == '0) ? SEL_W'(NUM_KEYS - 1) : sel_num_q - SEL_W'(1);
                        act       = 1'b1;
                    end
                end
                if (act) begin
                    sel_load_d = 1'b1;
                    calc_rst_d = 1'b1;
                    state_d    = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                calc_rst_d = 1'b1;
                if (vb_rise && (pressed == '0)) begin
                    calc_rst_d = 1'b0;
                    state_d    = WAIT_PRESS;
                end
            end
            default: state_d = WAIT_PRESS;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q      <= '0;
            tick_cnt_q   <= '0;
            disp_en_q    <= 1'b0;
            calc_en_q    <= 1'b0;
            vnotactive_q <= 1'b0;
            pix_out_q    <= '1;
            sel_num_q    <= SEL_W'(DEFAULT_SEL);
            sel_load_q   <= 1'b0;
            calc_rst_q   <= 1'b1;
            state_q      <= WAIT_PRESS;
        end else begin
            presc_q      <= presc_d;
            tick_cnt_q   <= tick_cnt_d;
            disp_en_q    <= disp_en_d;
            calc_en_q    <= calc_en_d;
            vnotactive_q <= vnotactive_d;
            pix_out_q    <= pix_out_d;
            sel_num_q    <= sel_num_d;
            sel_load_q   <= sel_load_d;
            calc_rst_q   <= calc_rst_d;
            state_q      <= state_d;
        end
    end

    assign pix_out   = pix_out_q;
    assign sel_num   = sel_num_q;
    assign sel_load  = sel_load_q;
    assign calc_rst  = calc_rst_q;
    assign calc_en   = calc_en_q;
    assign disp_en   = disp_en_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_display_ctrl_n.sv
// Bench for display_ctrl_n: per-cycle reference model, frame-level vector table,
// hand-written startup/reset sequences and randomized key traffic.
module tb_display_ctrl_n;
    import display_pkg::*;

    localparam int NK    = 10;
    localparam int SW    = 5;
    localparam int TW    = 4;
    localparam int SDISP = 2;
    localparam int SCALC = 4;
    localparam int DEB   = 2;
    localparam int DSEL  = 0;

    logic          CLK = 1'b0;
    logic          RST;
    logic          vnotactive;
    logic [NK-1:0] keys_n;
    logic          key_up_n, key_down_n;
    logic [2:0]    pix_in, pix_out;
    logic [SW-1:0] sel_num;
    logic          sel_load, calc_rst, calc_en, disp_en;
    state_e        state_dbg;

    display_ctrl_n #(
        .NUM_KEYS(NK), .SEL_W(SW), .COLOR_W(1), .TICK_W(TW),
        .STARTUP_DISP(SDISP), .STARTUP_CALC(SCALC), .DEBOUNCE(DEB), .DEFAULT_SEL(DSEL)
    ) dut (
        .CLK(CLK), .RST(RST), .vnotactive(vnotactive), .keys_n(keys_n),
        .key_up_n(key_up_n), .key_down_n(key_down_n), .pix_in(pix_in), .pix_out(pix_out),
        .sel_num(sel_num), .sel_load(sel_load), .calc_rst(calc_rst), .calc_en(calc_en),
        .disp_en(disp_en), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int load_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: selection follows the rules on whole-frame key histories.
    logic [SW-1:0] exp_q[$];
    int            m_cyc;
    logic          m_disp, m_calc, m_load, m_crst, m_wait, m_vq;
    logic [SW-1:0] m_sel;
    logic [2:0]    m_pix;
    logic [NK+1:0] hist[0:DEB];
    logic [NK+1:0] pr;
    logic          vb, stable, calc_prev, disp_prev, acted;
    int            lo, nsel;

    always @(posedge CLK) begin
        pr = ~{key_down_n, key_up_n, keys_n};
        vb = vnotactive && !m_vq;
        if (RST) begin
            m_cyc = 0; m_disp = 0; m_calc = 0; m_load = 0; m_crst = 1; m_wait = 0;
            m_vq = 0; m_sel = SW'(DSEL); m_pix = 3'b111;
            for (int i = 0; i <= DEB; i++) hist[i] = '0;
            exp_q.delete();
        end else begin
            disp_prev = m_disp;
            calc_prev = m_calc;
            m_cyc++;
            if (disp_prev) m_pix = pix_in;
            m_disp = (m_cyc >= SDISP * (2 ** TW));
            m_calc = (m_cyc >= SCALC * (2 ** TW));
            m_load = 0;
            if (vb) begin
                for (int i = DEB; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = pr;
                stable = (pr != '0);
                for (int i = 1; i <= DEB; i++) if (hist[i] != pr) stable = 0;
                if (!m_wait) begin
                    if (stable && calc_prev) begin
                        acted = 0;
                        lo = -1;
                        for (int i = NK - 1; i >= 0; i--) if (pr[i]) lo = i;
                        if (lo >= 0) begin
                            nsel = lo; acted = 1;
                        end else if (pr[NK] && !pr[NK+1]) begin
                            nsel = (int'(m_sel) + 1) % NK; acted = 1;
                        end else if (pr[NK+1] && !pr[NK]) begin
                            nsel = (int'(m_sel) + NK - 1) % NK; acted = 1;
                        end
                        if (acted) begin
                            m_sel = SW'(nsel); m_load = 1; m_wait = 1;
                            exp_q.push_back(SW'(nsel));
                        end
                    end
                end else if (pr == '0) begin
                    m_wait = 0;
                end
            end
            m_crst = m_wait;
            m_vq = vnotactive;
        end
        #1;
        check("m_sel_num", sel_num, m_sel);
        check("m_sel_load", sel_load, m_load);
        check("m_calc_rst", calc_rst, m_crst);
        check("m_calc_en", calc_en, m_calc);
        check("m_disp_en", disp_en, m_disp);
        check("m_pix_out", pix_out, m_pix);
        check("m_state", 32'(state_dbg), m_wait ? 32'(WAIT_RELEASE) : 32'(WAIT_PRESS));
        if (sel_load) begin
            if (exp_q.size() == 0) check("sb_unexpected_load", 1, 0);
            else check("sb_load_sel", sel_num, exp_q.pop_front());
        end
    end

    // Driver tasks
    logic [NK-1:0] cur_keys;
    logic          cur_up, cur_down;

    task automatic step(input logic v);
        vnotactive = v;
        pix_in = 3'($urandom);
        @(posedge CLK);
        #1;
        if (sel_load) load_seen++;
    endtask

    task automatic set_keys(input logic [NK-1:0] k, input logic u, input logic d);
        cur_keys = k; cur_up = u; cur_down = d;
        keys_n = k; key_up_n = u; key_down_n = d;
    endtask

    task automatic frame(input int lo_len, input bit glitch);
        for (int i = 0; i < lo_len; i++) step(1'b0);
        step(1'b1);
        if (glitch) begin
            keys_n = NK'($urandom); key_up_n = 1'($urandom); key_down_n = 1'($urandom);
        end
        step(1'b1);
        keys_n = cur_keys; key_up_n = cur_up; key_down_n = cur_down;
    endtask

    typedef struct {
        logic [NK-1:0] keys_n;
        logic          up_n;
        logic          down_n;
        int            frames;
        logic [SW-1:0] exp_sel;
        int            exp_loads;
        logic          exp_crst;
    } vec_t;

    localparam int NVEC = 18;
    localparam logic [NK-1:0] REL = '1;
    vec_t vecs[NVEC];

    initial begin
        vecs[0]  = '{10'h3F7, 1'b1, 1'b1, 3, 5'd3, 1, 1'b1};  // key 3
        vecs[1]  = '{REL,     1'b1, 1'b1, 1, 5'd3, 0, 1'b0};
        vecs[2]  = '{10'h1FF, 1'b1, 1'b1, 3, 5'd9, 1, 1'b1};  // key 9
        vecs[3]  = '{REL,     1'b1, 1'b1, 1, 5'd9, 0, 1'b0};
        vecs[4]  = '{REL,     1'b0, 1'b1, 3, 5'd0, 1, 1'b1};  // up wraps 9 -> 0
        vecs[5]  = '{REL,     1'b1, 1'b1, 1, 5'd0, 0, 1'b0};
        vecs[6]  = '{REL,     1'b1, 1'b0, 3, 5'd9, 1, 1'b1};  // down wraps 0 -> 9
        vecs[7]  = '{REL,     1'b1, 1'b1, 1, 5'd9, 0, 1'b0};
        vecs[8]  = '{10'h3DB, 1'b1, 1'b1, 3, 5'd2, 1, 1'b1};  // keys 5 and 2
        vecs[9]  = '{REL,     1'b1, 1'b1, 1, 5'd2, 0, 1'b0};
        vecs[10] = '{REL,     1'b0, 1'b0, 4, 5'd2, 0, 1'b0};  // up+down: no action
        vecs[11] = '{REL,     1'b1, 1'b1, 1, 5'd2, 0, 1'b0};
        vecs[12] = '{REL,     1'b1, 1'b0, 3, 5'd1, 1, 1'b1};
        vecs[13] = '{REL,     1'b1, 1'b1, 1, 5'd1, 0, 1'b0};
        vecs[14] = '{REL,     1'b0, 1'b1, 5, 5'd2, 1, 1'b1};  // held: single step
        vecs[15] = '{REL,     1'b1, 1'b1, 1, 5'd2, 0, 1'b0};
        vecs[16] = '{10'h37F, 1'b1, 1'b0, 3, 5'd7, 1, 1'b1};  // direct beats down
        vecs[17] = '{REL,     1'b1, 1'b1, 1, 5'd7, 0, 1'b0};

        // Clock/reset
        RST = 1'b1;
        vnotactive = 1'b0;
        pix_in = '0;
        set_keys(REL, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        check("rst_pix_out", pix_out, 3'b111);
        check("rst_sel_num", sel_num, DSEL);
        check("rst_sel_load", sel_load, 0);
        check("rst_calc_rst", calc_rst, 1);
        check("rst_calc_en", calc_en, 0);
        check("rst_disp_en", disp_en, 0);
        RST = 1'b0;

        // Startup, with key 6 pressed and released before calc_en
        load_seen = 0;
        set_keys(10'h3BF, 1'b1, 1'b1);
        for (int c = 1; c <= 72; c++) begin
            if (c == 40) set_keys(REL, 1'b1, 1'b1);
            step((c % 8) >= 6);
            if (c == 31) check("disp_en_c31", disp_en, 0);
            if (c == 32) check("disp_en_c32", disp_en, 1);
            if (c == 32) check("pix_hold_c32", pix_out, 3'b111);
            if (c == 63) check("calc_en_c63", calc_en, 0);
            if (c == 64) check("calc_en_c64", calc_en, 1);
        end
        check("precalc_loads", load_seen, 0);
        check("precalc_sel", sel_num, DSEL);

        // Vector table
        for (int v = 0; v < NVEC; v++) begin
            set_keys(vecs[v].keys_n, vecs[v].up_n, vecs[v].down_n);
            load_seen = 0;
            for (int f = 0; f < vecs[v].frames; f++) frame(6, 1'b0);
            check($sformatf("vec%0d_sel", v), sel_num, vecs[v].exp_sel);
            check($sformatf("vec%0d_loads", v), load_seen, vecs[v].exp_loads);
            check($sformatf("vec%0d_calc_rst", v), calc_rst, vecs[v].exp_crst);
        end

        // Key 4 toggling every frame never settles
        load_seen = 0;
        for (int f = 0; f < 6; f++) begin
            set_keys((f % 2 == 0) ? 10'h3EF : REL, 1'b1, 1'b1);
            frame(6, 1'b0);
        end
        set_keys(REL, 1'b1, 1'b1);
        frame(6, 1'b0);
        check("glitch_loads", load_seen, 0);
        check("glitch_sel", sel_num, 7);

        // Randomized traffic, with key noise on the non-sampling blanking cycle
        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 3))
                0: set_keys(REL, 1'b1, 1'b1);
                1: set_keys(~(NK'(1) << $urandom_range(0, NK - 1)), 1'b1, 1'b1);
                2: set_keys(REL, 1'($urandom), 1'($urandom));
                default: set_keys(NK'($urandom), 1'($urandom), 1'($urandom));
            endcase
            for (int f = $urandom_range(1, 4); f > 0; f--) frame($urandom_range(1, 6), 1'b1);
        end

        // Reset while holding the core in reset
        set_keys(REL, 1'b1, 1'b1);
        frame(6, 1'b0);
        set_keys(10'h2FF, 1'b1, 1'b1);
        for (int f = 0; f < 3; f++) frame(6, 1'b0);
        check("pre_rst_sel", sel_num, 8);
        check("pre_rst_state", 32'(state_dbg), 32'(WAIT_RELEASE));
        RST = 1'b1;
        step(1'b0);
        check("mid_rst_sel", sel_num, DSEL);
        check("mid_rst_disp_en", disp_en, 0);
        check("mid_rst_state", 32'(state_dbg), 32'(WAIT_PRESS));
        check("mid_rst_pix", pix_out, 3'b111);
        check("mid_rst_calc_rst", calc_rst, 1);
        RST = 1'b0;
        set_keys(REL, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0);
        check("restart_disp_en", disp_en, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
